// File: rtl/pll_pkg.sv
// Shared types and constants for the loop's SPI DAC transmit path.
package pll_pkg;

    localparam int DAC_FRAME_W      = 16;
    localparam int DAC_DATA_W       = 12;
    localparam int DAC_CFG_W        = DAC_FRAME_W - DAC_DATA_W;
    localparam int DAC_HALF_PERIODS = 32;
    localparam int DAC_BITCNT_W     = 5;
    localparam int DAC_TMR_W        = 8;

    // Buffered reference, 1x gain, output active.
    localparam logic [DAC_CFG_W-1:0] DAC_CFG_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        CS_HIGH,
        LDAC
    } dac_state_t;

    function automatic logic [DAC_FRAME_W-1:0] dac_frame(
        input logic [DAC_CFG_W-1:0]  cfg,
        input logic [DAC_DATA_W-1:0] data
    );
        return {cfg, data};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Word handshake between the loop filter and the DAC transmitter.
interface dac_spi_tx_if;
    import pll_pkg::*;

    logic [DAC_DATA_W-1:0] data_in;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in,
        output in_valid,
        input  in_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready,
        output busy,
        output done
    );

endinterface

// File: rtl/dac_halfper_timer.sv
// Loadable down-counter; tc marks the last cycle of an H-cycle phase.
module dac_halfper_timer
    import pll_pkg::*;
#(
    parameter int W = DAC_TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         tc_next
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Parks at zero when not reloaded, so an idle timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc      = (cnt_q == '0);
    assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises {CFG_BITS, data_in} MSB-first into an SPI DAC (mode 0), then pulses LDAC.
module dac_spi_tx
    import pll_pkg::*;
#(
    parameter int                   CLK_DIV  = 4,
    parameter logic [DAC_CFG_W-1:0] CFG_BITS = DAC_CFG_DEFAULT,
    parameter bit                   LDAC_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            swiptAlive,
    dac_spi_tx_if.slave     bus,
    output logic            dac_cs_n,
    output logic            dac_sclk,
    output logic            dac_mosi,
    output logic            dac_ldac_n
);

    localparam logic [DAC_TMR_W-1:0]    HALF_LOAD = DAC_TMR_W'(CLK_DIV - 1);
    localparam logic [DAC_BITCNT_W-1:0] LAST_HALF = DAC_BITCNT_W'(DAC_HALF_PERIODS - 1);
    localparam dac_state_t              LAST_ST   = LDAC_EN ? LDAC : CS_HIGH;

    dac_state_t              state_q, state_d;
    logic [DAC_FRAME_W-1:0]  shreg_q, shreg_d;
    logic [DAC_BITCNT_W-1:0] bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    mosi_q, mosi_d;
    logic                    ldac_n_q, ldac_n_d;
    logic                    done_q, done_d;
    logic                    tmr_load;
    logic                    tmr_tc;
    logic                    tmr_tc_next;
    logic                    accept;

    dac_halfper_timer #(.W(DAC_TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (HALF_LOAD),
        .tc       (tmr_tc),
        .tc_next  (tmr_tc_next)
    );

    assign bus.in_ready = (state_q == IDLE) && swiptAlive;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        ldac_n_d = ldac_n_q;
        tmr_load = 1'b0;

        if (state_q != IDLE && !swiptAlive) begin
            state_d  = IDLE;
            shreg_d  = '0;
            bit_d    = '0;
            sclk_d   = 1'b0;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            ldac_n_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d  = SETUP;
                        shreg_d  = dac_frame(CFG_BITS, bus.data_in);
                        bit_d    = '0;
                        cs_n_d   = 1'b0;
                        sclk_d   = 1'b0;
                        mosi_d   = CFG_BITS[DAC_CFG_W-1];
                        tmr_load = 1'b1;
                    end
                end
                SETUP: begin
                    if (tmr_tc) begin
                        state_d  = SHIFT;
                        sclk_d   = 1'b1;
                        bit_d    = '0;
                        tmr_load = 1'b1;
                    end
                end
                SHIFT: begin
                    if (tmr_tc) begin
                        tmr_load = 1'b1;
                        if (bit_q == LAST_HALF) begin
                            state_d = CS_HIGH;
                            bit_d   = '0;
                            sclk_d  = 1'b0;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + DAC_BITCNT_W'(1);
                            sclk_d = ~sclk_q;
                            // Advance data only as sclk falls so it is settled for the next rise.
                            if (sclk_q) begin
                                shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
                                mosi_d  = shreg_q[DAC_FRAME_W-2];
                            end
                        end
                    end
                end
                CS_HIGH: begin
                    if (tmr_tc) begin
                        tmr_load = 1'b1;
                        if (LDAC_EN) begin
                            state_d  = LDAC;
                            ldac_n_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                LDAC: begin
                    if (tmr_tc) begin
                        state_d  = IDLE;
                        ldac_n_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // done is registered, so it is raised when the next cycle is the final one of the frame.
    assign done_d = (state_d == LAST_ST) && tmr_tc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            ldac_n_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
            ldac_n_q <= ldac_n_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Transmit side of the loop's analog interface. Takes a 12-bit control word from the loop filter and serialises it into an external SPI DAC that drives the VCO tuning voltage.
- Frame is 16 bits, MSB first: a 4-bit config nibble followed by 12 data bits. An optional LDAC pulse latches the new value into the DAC output.
- Gated by swiptAlive. Loss of link aborts any frame in flight and holds the DAC interface idle.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period (H). Legal range 1..255.
- CFG_BITS, 4'b0011: config nibble sent as frame[15:12] (buffered, 1x gain, active).
- LDAC_EN, 1'b1: 1 = issue an LDAC pulse after each frame; 0 = skip the LDAC phase.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- swiptAlive  input  1  link alive; low = abort and idle
- data_in  input  12  DAC code
- in_valid  input  1  data_in valid
- in_ready  output  1  block can accept a word this cycle
- busy  output  1  frame in progress (any state other than IDLE)
- done  output  1  one-cycle pulse on the final cycle of a completed frame
- dac_cs_n  output  1  SPI chip select, active-low
- dac_sclk  output  1  SPI clock, mode 0 (idles low)
- dac_mosi  output  1  SPI data
- dac_ldac_n  output  1  DAC latch, active-low

Behaviour:
- Reset (async, rst=1): state=IDLE, dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1, done=0, busy=0, shift register=0, all counters=0.
- All outputs are registered. in_ready = (state==IDLE) && swiptAlive, decoded from the state register.
- Accept: in_valid && in_ready at clock edge t. The block latches frame={CFG_BITS,data_in} and enters SETUP at t+1.
- in_valid while in_ready=0 is ignored; no internal queue. Upstream must hold the word.
- States and durations:
  - IDLE: wait for accept.
  - SETUP: H cycles. cs_n=0, sclk=0, mosi=frame[15].
  - SHIFT: 32 half-periods of H cycles each. sclk toggles every H cycles, starting high. mosi changes only on sclk falling transitions, so it is stable across each rising edge. The 16th rising edge carries frame[0]. After the 16th high phase, sclk returns to 0 and the block enters CS_HIGH.
  - CS_HIGH: H cycles. cs_n=1, sclk=0, mosi=0.
  - LDAC: H cycles. ldac_n=0. Skipped when LDAC_EN=0.
  - Then back to IDLE.
- Timing: cs_n low for exactly 33H cycles. Frame length is 35H cycles (34H when LDAC_EN=0), occupying cycles t+1..t+35H.
- done=1 on the last frame cycle only. IDLE at t+35H+1, where a new word can be accepted.
- Bit counter: 5 bits, counts 0..31 half-periods. Half-period timer: 8 bits, reloads H-1, terminal count at 0. CLK_DIV=1 gives sclk = clk/2 with no stall cycle.
- swiptAlive low in any non-IDLE state: next cycle state=IDLE, cs_n=1, sclk=0, mosi=0, ldac_n=1. No done pulse. The partial frame is discarded and the DAC keeps its previous value.
- swiptAlive low in the same cycle as in_valid: no accept.
- rst asserted mid-frame: immediate async return to reset values. No done pulse.
- busy=1 in every state other than IDLE.

Decomposition:
- Package pll_pkg:
  - DAC_FRAME_W=16, DAC_DATA_W=12
  - default CFG nibble
  - state enum {IDLE, SETUP, SHIFT, CS_HIGH, LDAC}
- One sub-module, dac_halfper_timer: loadable down-counter with a terminal-count strobe, rst async. Used for all H-cycle phases.
- The FSM, shift register and bit counter stay in dac_spi_tx.

Test Plan:
- Basic frame. CLK_DIV=2, data_in=12'hA5C accepted at cycle 0.
  - MOSI sampled on 16 SCLK rising edges = 0011_1010_0101_1100 (16'h3A5C).
  - cs_n low for 66 cycles; ldac_n low for 2 cycles.
  - done at cycle 70; in_ready=1 at cycle 71.
- Back-to-back. in_valid held high with 12'h000, then 12'hFFF.
  - Two frames, 16'h3000 then 16'h3FFF.
  - Second accept at cycle 71; in_ready=0 throughout cycles 1..70.
- LDAC_EN=0, CLK_DIV=1, data 12'h800.
  - Frame 16'h3800; sclk period is 2 clk.
  - done at cycle 34; ldac_n never low.
- swiptAlive dropped at cycle 20 of a frame (CLK_DIV=2).
  - cs_n=1 and sclk=0 at cycle 21; no done; no ldac pulse.
  - in_ready stays 0 until swiptAlive returns.
- rst pulsed mid-SHIFT, asynchronous and not aligned to clk.
  - All outputs at reset values immediately, with no clk edge needed.
  - A fresh word after release transmits a correct full frame.
- in_valid asserted with swiptAlive=0.
  - No accept; busy stays 0; all DAC pins idle.
